// File: rtl/ps2_mouse_pkg.sv
// Shared PS/2 mouse command/response codes, controller states and the init script lookup.
package ps2_mouse_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERROR    = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] ID_STD       = 8'h00;

    typedef enum logic [3:0] {
        ST_RESET_DLY,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_ACK,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_RESTART,
        ST_FAIL,
        ST_STREAM
    } state_t;

    // Init script: reset, set sample rate + argument, enable data reporting.
    function automatic logic [7:0] script_byte(input logic [1:0] idx, input logic [7:0] rate);
        case (idx)
            2'd0:    script_byte = CMD_RESET;
            2'd1:    script_byte = CMD_SET_RATE;
            2'd2:    script_byte = rate;
            default: script_byte = CMD_ENABLE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_packet_assembler.sv
// Frames 3-byte PS/2 movement packets from the receive byte stream while enabled.
module ps2_packet_assembler #(
    parameter int ACK_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [1:0] ovf
);

    localparam int GW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LIMIT = GW'(ACK_TIMEOUT - 1);

    logic [1:0]    cnt;
    logic [6:0]    hdr;
    logic [7:0]    byte1;
    logic [GW-1:0] gap;

    // hdr keeps byte 0 without its always-one sync bit: {ovf[1:0], ysign, xsign, btn[2:0]}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hdr       <= '0;
            byte1     <= '0;
            gap       <= '0;
            pkt_valid <= 1'b0;
            btn       <= '0;
            dx        <= '0;
            dy        <= '0;
            ovf       <= '0;
        end else begin
            pkt_valid <= 1'b0;
            if (!enable || rx_err) begin
                cnt <= '0;
                gap <= '0;
            end else if (rx_valid) begin
                gap <= '0;
                case (cnt)
                    2'd0: begin
                        if (rx_data[3]) begin
                            hdr <= {rx_data[7:4], rx_data[2:0]};
                            cnt <= 2'd1;
                        end
                    end
                    2'd1: begin
                        byte1 <= rx_data;
                        cnt   <= 2'd2;
                    end
                    default: begin
                        pkt_valid <= 1'b1;
                        btn       <= hdr[2:0];
                        dx        <= {hdr[3], byte1};
                        dy        <= {hdr[4], rx_data};
                        ovf       <= hdr[6:5];
                        cnt       <= 2'd0;
                    end
                endcase
            end else if (cnt != 2'd0) begin
                // Drop a partial packet once the line has been idle for ACK_TIMEOUT cycles.
                if (gap >= GAP_LIMIT) begin
                    cnt <= '0;
                    gap <= '0;
                end else begin
                    gap <= gap + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up sequencer: runs the init script with retries, then frames stream packets.
module ps2_mouse_init_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int         ACK_TIMEOUT = 1_000_000,
    parameter int         BAT_TIMEOUT = 30_000_000,
    parameter logic [7:0] SAMPLE_RATE = 8'h64,
    parameter int         MAX_RETRY   = 3
) (
    input  logic       CLK,
    input  logic       RST,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_done,
    input  logic       tx_err,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_err,
    output logic       STREAM,
    output logic       FAIL,
    output logic       pkt_valid,
    output logic [2:0] btn,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [1:0] ovf
);

    localparam int TW = $clog2(BAT_TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] ACK_LIMIT = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] BAT_LIMIT = TW'(BAT_TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t        state;
    logic [1:0]    idx;
    logic [RW-1:0] retry;
    logic [1:0]    fe_cnt;
    logic [TW-1:0] timer;

    // Timer defaults to clear, so it is zero on entry to every WAIT_* state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_RESET_DLY;
            idx      <= '0;
            retry    <= '0;
            fe_cnt   <= '0;
            timer    <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            STREAM   <= 1'b0;
            FAIL     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            timer    <= '0;
            case (state)
                ST_RESET_DLY: state <= ST_SEND;
                ST_SEND: begin
                    tx_data  <= script_byte(idx, SAMPLE_RATE);
                    tx_start <= 1'b1;
                    state    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_err)             state <= ST_RESTART;
                    else if (tx_done)       state <= ST_WAIT_ACK;
                    else if (timer != '1)   timer <= timer + 1'b1;
                end
                ST_WAIT_ACK: begin
                    if (rx_err) begin
                        state <= ST_RESTART;
                    end else if (rx_valid) begin
                        case (rx_data)
                            RSP_ACK: begin
                                fe_cnt <= '0;
                                if (idx == 2'd0) begin
                                    state <= ST_WAIT_BAT;
                                end else if (idx == 2'd3) begin
                                    STREAM <= 1'b1;
                                    state  <= ST_STREAM;
                                end else begin
                                    idx   <= idx + 2'd1;
                                    state <= ST_SEND;
                                end
                            end
                            RSP_RESEND: begin
                                // A third consecutive resend is treated as a hard failure.
                                if (fe_cnt == 2'd2) begin
                                    state <= ST_RESTART;
                                end else begin
                                    fe_cnt <= fe_cnt + 2'd1;
                                    state  <= ST_SEND;
                                end
                            end
                            RSP_ERROR: state <= ST_RESTART;
                            default:   state <= ST_RESTART;
                        endcase
                    end else if (timer >= ACK_LIMIT) begin
                        state <= ST_RESTART;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_BAT: begin
                    if (rx_err)                 state <= ST_RESTART;
                    else if (rx_valid) begin
                        if (rx_data == RSP_BAT_OK)     state <= ST_WAIT_ID;
                        else if (rx_data == RSP_ERROR) state <= ST_RESTART;
                        else                           state <= ST_RESTART;
                    end
                    else if (timer >= BAT_LIMIT) state <= ST_RESTART;
                    else                         timer <= timer + 1'b1;
                end
                ST_WAIT_ID: begin
                    if (rx_err) begin
                        state <= ST_RESTART;
                    end else if (rx_valid) begin
                        if (rx_data == ID_STD) begin
                            idx   <= 2'd1;
                            state <= ST_SEND;
                        end else begin
                            state <= ST_RESTART;
                        end
                    end else if (timer >= ACK_LIMIT) begin
                        state <= ST_RESTART;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESTART: begin
                    fe_cnt <= '0;
                    if (retry < RETRY_MAX) begin
                        retry <= retry + 1'b1;
                        idx   <= '0;
                        state <= ST_SEND;
                    end else begin
                        FAIL  <= 1'b1;
                        state <= ST_FAIL;
                    end
                end
                ST_FAIL:   state <= ST_FAIL;
                ST_STREAM: state <= ST_STREAM;
                default:   state <= ST_RESET_DLY;
            endcase
        end
    end

    ps2_packet_assembler #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_assembler (
        .clk      (CLK),
        .rst_n    (RST),
        .enable   (STREAM),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .pkt_valid(pkt_valid),
        .btn      (btn),
        .dx       (dx),
        .dy       (dy),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl: init script, resend, timeouts, BAT error, packet framing.
module tb_ps2_mouse_init_ctrl;

    localparam int ACK_T = 40;
    localparam int BAT_T = 100;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done = 1'b0;
    logic       tx_err = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_err = 1'b0;
    logic       STREAM;
    logic       FAIL;
    logic       pkt_valid;
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;

    int total = 0;
    int bad = 0;
    int tx_count = 0;
    int pkt_count = 0;

    always #5 CLK = ~CLK;

    ps2_mouse_init_ctrl #(
        .ACK_TIMEOUT(ACK_T),
        .BAT_TIMEOUT(BAT_T),
        .SAMPLE_RATE(8'h64),
        .MAX_RETRY(3)
    ) dut (
        .CLK(CLK), .RST(RST),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .tx_err(tx_err),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .STREAM(STREAM), .FAIL(FAIL),
        .pkt_valid(pkt_valid), .btn(btn), .dx(dx), .dy(dy), .ovf(ovf)
    );

    // Pulse counters sample pre-edge values, so each one-cycle pulse counts once.
    always @(posedge CLK) begin
        if (tx_start === 1'b1) tx_count <= tx_count + 1;
        if (pkt_valid === 1'b1) pkt_count <= pkt_count + 1;
    end

    task automatic apply_reset;
        tx_done = 0; tx_err = 0; rx_valid = 0; rx_err = 0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic wait_tx(output bit found, output logic [7:0] data);
        found = 1'b0;
        data  = 8'h00;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (tx_start === 1'b1) begin
                found = 1'b1;
                data  = tx_data;
                break;
            end
        end
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        @(negedge CLK);
        tx_done = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] resp, output bit found, output logic [7:0] data);
        wait_tx(found, data);
        if (found) begin
            pulse_done();
            send_rx(resp);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin bad++;
            $display("[TB] FAIL reset_tx: got start=%b data=%h want 0/00", tx_start, tx_data); end
        total++; if (STREAM !== 1'b0 || FAIL !== 1'b0) begin bad++;
            $display("[TB] FAIL reset_status: got STREAM=%b FAIL=%b want 0/0", STREAM, FAIL); end
        total++; if ({pkt_valid, btn, dx, dy, ovf} !== '0) begin bad++;
            $display("[TB] FAIL reset_pkt: got v=%b btn=%h dx=%h dy=%h ovf=%h want all 0",
                     pkt_valid, btn, dx, dy, ovf); end
        RST = 1'b1;
    endtask

    task automatic test_ideal_init;
        logic [7:0] exp_seq [4] = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
        bit found;
        logic [7:0] data;
        int base;
        base = tx_count;
        for (int i = 0; i < 4; i++) begin
            wait_tx(found, data);
            total++; if (!found || data !== exp_seq[i]) begin bad++;
                $display("[TB] FAIL ideal_tx%0d: got found=%b data=%h want %h", i, found, data, exp_seq[i]); end
            pulse_done();
            if (i == 3) begin
                total++; if (STREAM !== 1'b0) begin bad++;
                    $display("[TB] FAIL ideal_stream_early: got %b want 0", STREAM); end
            end
            send_rx(8'hFA);
            if (i == 0) begin
                send_rx(8'hAA);
                send_rx(8'h00);
            end
        end
        total++; if (STREAM !== 1'b1 || FAIL !== 1'b0) begin bad++;
            $display("[TB] FAIL ideal_stream: got STREAM=%b FAIL=%b want 1/0", STREAM, FAIL); end
        repeat (2) @(negedge CLK);
        total++; if (tx_count - base !== 4) begin bad++;
            $display("[TB] FAIL ideal_tx_count: got %0d want 4", tx_count - base); end
    endtask

    task automatic test_resend;
        logic [7:0] exp_seq [5] = '{8'hFF, 8'hF3, 8'hF3, 8'h64, 8'hF4};
        logic [7:0] rsp_seq [5] = '{8'hFA, 8'hFE, 8'hFA, 8'hFA, 8'hFA};
        bit found;
        logic [7:0] data;
        int base;
        apply_reset();
        base = tx_count;
        for (int i = 0; i < 5; i++) begin
            run_cmd(rsp_seq[i], found, data);
            total++; if (!found || data !== exp_seq[i]) begin bad++;
                $display("[TB] FAIL resend_tx%0d: got found=%b data=%h want %h", i, found, data, exp_seq[i]); end
            if (i == 0) begin
                send_rx(8'hAA);
                send_rx(8'h00);
            end
        end
        total++; if (STREAM !== 1'b1 || FAIL !== 1'b0) begin bad++;
            $display("[TB] FAIL resend_stream: got STREAM=%b FAIL=%b want 1/0", STREAM, FAIL); end
        repeat (2) @(negedge CLK);
        total++; if (tx_count - base !== 5) begin bad++;
            $display("[TB] FAIL resend_tx_count: got %0d want 5", tx_count - base); end
    endtask

    task automatic test_no_reply;
        bit found;
        logic [7:0] data;
        int base;
        int gap;
        apply_reset();
        base = tx_count;
        wait_tx(found, data);
        total++; if (!found || data !== 8'hFF) begin bad++;
            $display("[TB] FAIL noreply_tx1: got found=%b data=%h want FF", found, data); end
        // tx_done edge, ACK_T+1 counting edges, RESTART, SEND, then tx_start seen at the next negedge.
        pulse_done();
        gap = 1;
        while (tx_start !== 1'b1 && gap < 400) begin
            @(negedge CLK);
            gap++;
        end
        total++; if (gap !== ACK_T + 4 || tx_data !== 8'hFF) begin bad++;
            $display("[TB] FAIL noreply_timeout: got gap=%0d data=%h want %0d/FF", gap, tx_data, ACK_T + 4); end
        repeat (2) begin
            pulse_done();
            wait_tx(found, data);
            total++; if (!found || data !== 8'hFF) begin bad++;
                $display("[TB] FAIL noreply_retry: got found=%b data=%h want FF", found, data); end
        end
        pulse_done();
        repeat (ACK_T + 10) @(negedge CLK);
        total++; if (FAIL !== 1'b1 || STREAM !== 1'b0) begin bad++;
            $display("[TB] FAIL noreply_fail: got FAIL=%b STREAM=%b want 1/0", FAIL, STREAM); end
        total++; if (tx_count - base !== 4) begin bad++;
            $display("[TB] FAIL noreply_attempts: got %0d want 4", tx_count - base); end
        send_rx(8'hFA);
        send_rx(8'hAA);
        send_rx(8'h00);
        pulse_done();
        tx_err = 1'b1; @(negedge CLK); tx_err = 1'b0;
        repeat (5) @(negedge CLK);
        total++; if (FAIL !== 1'b1 || STREAM !== 1'b0 || tx_start !== 1'b0 || tx_count - base !== 4) begin bad++;
            $display("[TB] FAIL noreply_sticky: got FAIL=%b STREAM=%b start=%b n=%0d want 1/0/0/4",
                     FAIL, STREAM, tx_start, tx_count - base); end
    endtask

    task automatic test_bat_error;
        logic [7:0] exp_seq [5] = '{8'hFF, 8'hFF, 8'hF3, 8'h64, 8'hF4};
        bit found;
        logic [7:0] data;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            run_cmd(8'hFA, found, data);
            total++; if (!found || data !== exp_seq[i]) begin bad++;
                $display("[TB] FAIL baterr_tx%0d: got found=%b data=%h want %h", i, found, data, exp_seq[i]); end
            if (i == 0) send_rx(8'hFC);
            if (i == 1) begin
                send_rx(8'hAA);
                send_rx(8'h00);
            end
        end
        total++; if (STREAM !== 1'b1 || FAIL !== 1'b0) begin bad++;
            $display("[TB] FAIL baterr_stream: got STREAM=%b FAIL=%b want 1/0", STREAM, FAIL); end
    endtask

    task automatic test_packets;
        int base;
        base = pkt_count;
        // Byte 0 = 28: sync bit plus Y sign, so dy = {1, FB} = -5.
        send_rx(8'h28); send_rx(8'h05); send_rx(8'hFB);
        total++; if (pkt_valid !== 1'b1 || btn !== 3'b000 || dx !== 9'h005 || dy !== 9'h1FB || ovf !== 2'b00) begin bad++;
            $display("[TB] FAIL pkt1: got v=%b btn=%b dx=%h dy=%h ovf=%b want 1/000/005/1fb/00",
                     pkt_valid, btn, dx, dy, ovf); end
        @(negedge CLK);
        total++; if (pkt_valid !== 1'b0 || dx !== 9'h005) begin bad++;
            $display("[TB] FAIL pkt1_hold: got v=%b dx=%h want 0/005", pkt_valid, dx); end
        send_rx(8'h00); send_rx(8'h09); send_rx(8'h01); send_rx(8'h02);
        total++; if (pkt_valid !== 1'b1 || btn !== 3'b001 || dx !== 9'h001 || dy !== 9'h002 || ovf !== 2'b00) begin bad++;
            $display("[TB] FAIL pkt2_resync: got v=%b btn=%b dx=%h dy=%h ovf=%b want 1/001/001/002/00",
                     pkt_valid, btn, dx, dy, ovf); end
        send_rx(8'hCE); send_rx(8'h7F); send_rx(8'h80);
        total++; if (pkt_valid !== 1'b1 || btn !== 3'b110 || dx !== 9'h07F || dy !== 9'h080 || ovf !== 2'b11) begin bad++;
            $display("[TB] FAIL pkt3_ovf: got v=%b btn=%b dx=%h dy=%h ovf=%b want 1/110/07f/080/11",
                     pkt_valid, btn, dx, dy, ovf); end
        repeat (2) @(negedge CLK);
        total++; if (pkt_count - base !== 3) begin bad++;
            $display("[TB] FAIL pkt_count: got %0d want 3", pkt_count - base); end
    endtask

    task automatic test_gap;
        int base;
        base = pkt_count;
        send_rx(8'h08); send_rx(8'h05);
        repeat (ACK_T) @(negedge CLK);
        send_rx(8'h18); send_rx(8'hFF); send_rx(8'h00);
        total++; if (pkt_valid !== 1'b1 || btn !== 3'b000 || dx !== 9'h1FF || dy !== 9'h000 || ovf !== 2'b00) begin bad++;
            $display("[TB] FAIL gap_pkt: got v=%b btn=%b dx=%h dy=%h ovf=%b want 1/000/1ff/000/00",
                     pkt_valid, btn, dx, dy, ovf); end
        repeat (2) @(negedge CLK);
        total++; if (pkt_count - base !== 1) begin bad++;
            $display("[TB] FAIL gap_count: got %0d want 1", pkt_count - base); end
    endtask

    task automatic test_reset_mid;
        bit found;
        logic [7:0] data;
        send_rx(8'h08);
        RST = 1'b0;
        #1;
        total++; if ({tx_start, tx_data, STREAM, FAIL, pkt_valid, btn, dx, dy, ovf} !== '0) begin bad++;
            $display("[TB] FAIL midreset_outputs: got start=%b data=%h S=%b F=%b v=%b btn=%b dx=%h dy=%h ovf=%b want all 0",
                     tx_start, tx_data, STREAM, FAIL, pkt_valid, btn, dx, dy, ovf); end
        @(negedge CLK);
        RST = 1'b1;
        wait_tx(found, data);
        total++; if (!found || data !== 8'hFF) begin bad++;
            $display("[TB] FAIL midreset_restart: got found=%b data=%h want FF", found, data); end
    endtask

    initial begin
        test_reset();
        test_ideal_init();
        test_resend();
        test_no_reply();
        test_bat_error();
        test_packets();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
